// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM with redirect
// handling, response draining and a one-entry instruction hold register.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr_data;
   logic [31:0] r_instr_pc;
   logic        r_fetch_err;

   logic [31:0] w_redirect_pc_al;
   logic        w_misaligned;

   assign w_redirect_pc_al = {redirect_pc[31:2], 2'b00};
   assign w_misaligned     = |redirect_pc[1:0];

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_instr_data <= 32'h0;
         r_instr_pc   <= 32'h0;
         r_fetch_err  <= 1'b0;
      end else begin
         r_fetch_err <= redirect && w_misaligned;
         case (r_state)
            S_IDLE: begin
               if (redirect) r_pc <= w_redirect_pc_al;
               r_state <= S_REQ;
            end
            S_REQ: begin
               if (redirect) r_pc <= w_redirect_pc_al;
               // A granted request whose address was just redirected still returns data.
               if (mem_gnt) r_state <= redirect ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
               if (redirect) begin
                  r_pc    <= w_redirect_pc_al;
                  r_state <= mem_rvalid ? S_REQ : S_DRAIN;
               end else if (mem_rvalid) begin
                  r_instr_data <= mem_rdata;
                  r_instr_pc   <= r_pc;
                  r_pc         <= r_pc + 32'd4;
                  r_state      <= S_HOLD;
               end
            end
            S_DRAIN: begin
               if (redirect) r_pc <= w_redirect_pc_al;
               if (mem_rvalid) r_state <= S_REQ;
            end
            S_HOLD: begin
               if (redirect) begin
                  r_pc    <= w_redirect_pc_al;
                  r_state <= S_REQ;
               end else if (instr_ready) begin
                  r_state <= S_REQ;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req     = (r_state == S_REQ);
   assign mem_addr    = r_pc;
   assign instr_valid = (r_state == S_HOLD);
   assign instr_data  = r_instr_data;
   assign instr_pc    = r_instr_pc;
   assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, streaming, stalls, redirects,
// address wrap and mid-flight reset, with hand-computed expectations.
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      cyc(); cyc();
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_data", instr_data, 32'h0);
      check("rst_pc", instr_pc, 32'h0);
      check("rst_err", {31'h0, fetch_err}, 32'h0);

      // Zero-wait streaming: REQ -> WAIT -> HOLD, one instruction per 3 cycles
      rst = 1'b0; mem_gnt = 1'b1;
      cyc();                                      // IDLE -> REQ
      check("first_req", {31'h0, mem_req}, 32'h1);
      check("first_addr", mem_addr, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; instr_ready = 1'b1;
      cyc();                                      // REQ -> WAIT (rvalid ignored)
      check("wait0_req", {31'h0, mem_req}, 32'h0);
      check("wait0_valid", {31'h0, instr_valid}, 32'h0);
      cyc();                                      // WAIT -> HOLD
      check("hold0_valid", {31'h0, instr_valid}, 32'h1);
      check("hold0_data", instr_data, 32'h0000_0013);
      check("hold0_pc", instr_pc, 32'h0);
      cyc();                                      // HOLD -> REQ
      check("req1_req", {31'h0, mem_req}, 32'h1);
      check("req1_addr", mem_addr, 32'h4);
      check("req1_valid", {31'h0, instr_valid}, 32'h0);
      mem_rdata = 32'h0000_0093;
      cyc(); cyc();                               // REQ -> WAIT -> HOLD
      check("hold1_pc", instr_pc, 32'h4);
      check("hold1_data", instr_data, 32'h0000_0093);
      cyc();
      check("req2_addr", mem_addr, 32'h8);

      // Grant stall: request and address stay put
      mem_gnt = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("stall_req", {31'h0, mem_req}, 32'h1);
         check("stall_addr", mem_addr, 32'h8);
      end
      mem_gnt = 1'b1;
      cyc();                                      // -> WAIT
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0001;
      cyc();                                      // -> HOLD
      mem_rvalid = 1'b0;
      // Core backpressure: held instruction stable, no new request
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("bp_valid", {31'h0, instr_valid}, 32'h1);
         check("bp_data", instr_data, 32'hA5A5_0001);
         check("bp_pc", instr_pc, 32'h8);
         check("bp_req", {31'h0, mem_req}, 32'h0);
      end
      instr_ready = 1'b1;
      cyc();                                      // -> REQ
      instr_ready = 1'b0;
      check("bp_next_addr", mem_addr, 32'hC);

      // Redirect during WAIT, stale response drained
      mem_gnt = 1'b1;
      cyc();                                      // -> WAIT
      mem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
      cyc();                                      // -> DRAIN
      redirect = 1'b0;
      check("drain_req", {31'h0, mem_req}, 32'h0);
      check("drain_addr", mem_addr, 32'h0000_0100);
      check("drain_err", {31'h0, fetch_err}, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      cyc();                                      // -> REQ, data discarded
      mem_rvalid = 1'b0;
      check("drained_valid", {31'h0, instr_valid}, 32'h0);
      check("drained_req", {31'h0, mem_req}, 32'h1);
      check("drained_addr", mem_addr, 32'h0000_0100);

      // Misaligned redirect in HOLD with instr_ready=1
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      cyc();                                      // -> HOLD
      mem_rvalid = 1'b0;
      check("hold_r_pc", instr_pc, 32'h0000_0100);
      redirect = 1'b1; redirect_pc = 32'h0000_0203; instr_ready = 1'b1;
      cyc();                                      // -> REQ, dropped
      redirect = 1'b0; instr_ready = 1'b0;
      check("mis_err", {31'h0, fetch_err}, 32'h1);
      check("mis_valid", {31'h0, instr_valid}, 32'h0);
      check("mis_addr", mem_addr, 32'h0000_0200);
      cyc();                                      // stays REQ (no grant)
      check("mis_err_end", {31'h0, fetch_err}, 32'h0);
      check("mis_req", {31'h0, mem_req}, 32'h1);

      // Redirect in REQ without grant, then wrap at top of address space
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      cyc();
      redirect = 1'b0;
      check("top_addr", mem_addr, 32'hFFFF_FFFC);
      check("top_req", {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      cyc();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0022; instr_ready = 1'b1;
      cyc();                                      // -> HOLD
      mem_rvalid = 1'b0;
      check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_data", instr_data, 32'h0000_0022);
      cyc();                                      // -> REQ
      instr_ready = 1'b0;
      check("wrap_addr", mem_addr, 32'h0);

      // Redirect in REQ with grant -> DRAIN
      redirect = 1'b1; redirect_pc = 32'h0000_0040; mem_gnt = 1'b1;
      cyc();
      redirect = 1'b0; mem_gnt = 1'b0;
      check("rg_req", {31'h0, mem_req}, 32'h0);
      check("rg_addr", mem_addr, 32'h0000_0040);
      cyc();
      check("rg_still_drain", {31'h0, mem_req}, 32'h0);
      mem_rvalid = 1'b1;
      cyc();
      mem_rvalid = 1'b0;
      check("rg_req2", {31'h0, mem_req}, 32'h1);
      check("rg_valid", {31'h0, instr_valid}, 32'h0);

      // Asynchronous reset mid-WAIT, stray rvalid afterwards
      mem_gnt = 1'b1;
      cyc();                                      // -> WAIT
      mem_gnt = 1'b0;
      check("pre_rst_data", instr_data, 32'h0000_0022);
      #2 rst = 1'b1;
      #1;
      check("arst_req", {31'h0, mem_req}, 32'h0);
      check("arst_addr", mem_addr, 32'h0);
      check("arst_data", instr_data, 32'h0);
      check("arst_pc", instr_pc, 32'h0);
      check("arst_valid", {31'h0, instr_valid}, 32'h0);
      cyc();
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
      cyc();                                      // IDLE -> REQ
      check("post_rst_req", {31'h0, mem_req}, 32'h1);
      check("post_rst_addr", mem_addr, 32'h0);
      cyc();                                      // stray rvalid in REQ ignored
      mem_rvalid = 1'b0;
      check("stray_req", {31'h0, mem_req}, 32'h1);
      check("stray_valid", {31'h0, instr_valid}, 32'h0);
      check("stray_data", instr_data, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
